step_pattern_sequencer: RTL

// Consumes debounced 4-bit button presses from the 4x4 button matrix controller
//   and toggles the matching bit of a 16-step beat pattern.

---
 rtl/step_pattern_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/step_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : step_pattern_sequencer
//  Purpose  : 16-step beat-pattern sequencer. Debounced button presses toggle
//             pattern bits, a tempo timer walks a playhead over the 16 steps,
//             and armed steps emit a fixed-width trigger pulse.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             press_valid/index - debounced press and its step index
//             play / stop       - transport control levels (stop wins)
//             clear             - zero the whole pattern
//             pattern           - current 16-bit pattern (bit n = step n)
//             step_index        - playhead position
//             step_strobe       - 1-cycle pulse on each new step while running
//             trigger           - TRIG_LEN-cycle pulse on armed steps
//             running           - high while playing
//  Revision : 1.0  initial release
// ============================================================================
module step_pattern_sequencer #(
  parameter int unsigned STEP_TICKS = 1_500_000,
  parameter int unsigned TRIG_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        press_valid,
  input  logic [3:0]  press_index,
  input  logic        play,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] pattern,
  output logic [3:0]  step_index,
  output logic        step_strobe,
  output logic        trigger,
  output logic        running
);

  localparam int unsigned TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned TRIG_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_LEN - 1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t              state_q;
  logic [15:0]         pattern_q;
  logic                press_q;
  logic [3:0]          step_q;
  logic                strobe_q;
  logic                trig_q;
  logic                running_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [TRIG_W-1:0]   trig_cnt_q;

  logic                press_rise;
  logic [3:0]          step_next;

  assign press_rise = press_valid & ~press_q;
  assign step_next  = step_q + 4'd1;

  // --------------------------------------------------------------------------
  // Pattern editing: one toggle per press (rising edge of press_valid);
  // clear dominates any toggle in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= 16'h0000;
      press_q   <= 1'b0;
    end else begin
      press_q <= press_valid;
      if (clear) begin
        pattern_q <= 16'h0000;
      end else if (press_rise) begin
        pattern_q[press_index] <= ~pattern_q[press_index];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transport FSM, tempo timer and trigger pulse. Trigger decisions read
  // pattern_q as it stands before this edge, so a toggle landing on the live
  // step only takes effect on the next lap.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STOPPED;
      step_q     <= 4'd0;
      strobe_q   <= 1'b0;
      trig_q     <= 1'b0;
      running_q  <= 1'b0;
      tick_cnt_q <= '0;
      trig_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          tick_cnt_q <= '0;
          strobe_q   <= 1'b0;
          trig_q     <= 1'b0;
          trig_cnt_q <= '0;
          if (play && !stop) begin
            state_q    <= ST_RUNNING;
            running_q  <= 1'b1;
            strobe_q   <= 1'b1;
            trig_q     <= pattern_q[step_q];
            trig_cnt_q <= TRIG_LAST;
          end
        end

        ST_RUNNING: begin
          if (stop) begin
            // Rewind; any advance due this cycle is dropped and the pulse cut.
            state_q    <= ST_STOPPED;
            running_q  <= 1'b0;
            step_q     <= 4'd0;
            tick_cnt_q <= '0;
            strobe_q   <= 1'b0;
            trig_q     <= 1'b0;
            trig_cnt_q <= '0;
          end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
            step_q     <= step_next;
            strobe_q   <= 1'b1;
            trig_q     <= pattern_q[step_next];
            trig_cnt_q <= TRIG_LAST;
          end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            strobe_q   <= 1'b0;
            // trig_cnt_q holds the number of high cycles still to come.
            if (trig_q) begin
              if (trig_cnt_q == '0) begin
                trig_q <= 1'b0;
              end else begin
                trig_cnt_q <= trig_cnt_q - TRIG_W'(1);
              end
            end
          end
        end

        default: begin
          state_q   <= ST_STOPPED;
          running_q <= 1'b0;
          strobe_q  <= 1'b0;
          trig_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pattern     = pattern_q;
  assign step_index  = step_q;
  assign step_strobe = strobe_q;
  assign trigger     = trig_q;
  assign running     = running_q;

endmodule
`default_nettype wire
